// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - state and lane encodings shared by the gate scheduler
package parking_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT_PW = 3'd1;
    localparam logic [2:0] ST_DENY    = 3'd2;
    localparam logic [2:0] ST_ENTER   = 3'd3;
    localparam logic [2:0] ST_EXIT    = 3'd4;
    localparam logic [2:0] ST_ALARM   = 3'd5;

    localparam logic LANE_ENTRY = 1'b0;
    localparam logic LANE_EXIT  = 1'b1;

    localparam int TMR_W = 8;

endpackage

// File: rtl/parking_gate_timer.sv
// rtl/parking_gate_timer.sv - loadable down-counter; done while the count sits at zero
module parking_gate_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/parking_gate_scheduler.sv
// rtl/parking_gate_scheduler.sv - shared barrier sequencing, password check and occupancy
module parking_gate_scheduler
    import parking_pkg::*;
#(
    parameter int         CAPACITY   = 8,
    parameter int         CNT_W      = 4,
    parameter logic [1:0] PASS_1     = 2'b01,
    parameter logic [1:0] PASS_2     = 2'b10,
    parameter int         GATE_CYC   = 4,
    parameter int         PW_TIMEOUT = 8,
    parameter int         MAX_TRIES  = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             entry_sensor_i,
    input  logic             exit_sensor_i,
    input  logic             pw_valid_i,
    input  logic [1:0]       password_1_i,
    input  logic [1:0]       password_2_i,
    input  logic             alarm_clr_i,
    output logic             gate_open_o,
    output logic             gate_lane_o,
    output logic             green_led_o,
    output logic             red_led_o,
    output logic [CNT_W-1:0] parked_spaces_o,
    output logic [CNT_W-1:0] available_spaces_o,
    output logic             full_o,
    output logic             busy_o,
    output logic             alarm_o
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    logic [2:0]       state_q, state_d;
    logic             lane_q, lane_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic [CNT_W-1:0] parked_q, parked_d;
    logic             pulse_q, pulse_d;
    logic             tmr_load, tmr_done;
    logic [TMR_W-1:0] tmr_val;
    logic             entry_ok, exit_ok, full;

    assign full     = (parked_q == CNT_W'(CAPACITY));
    assign entry_ok = entry_sensor_i && !full;
    assign exit_ok  = exit_sensor_i && (parked_q != '0);

    parking_gate_timer #(.W(TMR_W)) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        tries_d  = tries_q;
        parked_d = parked_q;
        pulse_d  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                // With both lanes eligible, the lane not served last time wins.
                if (entry_ok && (!exit_ok || lane_q == LANE_EXIT)) begin
                    state_d  = ST_WAIT_PW;
                    lane_d   = LANE_ENTRY;
                    tries_d  = '0;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(PW_TIMEOUT - 1);
                end else if (exit_ok) begin
                    state_d  = ST_EXIT;
                    lane_d   = LANE_EXIT;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(GATE_CYC - 1);
                end
            end
            ST_WAIT_PW: begin
                if (pw_valid_i) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(GATE_CYC - 1);
                    if (password_1_i == PASS_1 && password_2_i == PASS_2) begin
                        state_d = ST_ENTER;
                    end else begin
                        tries_d = tries_q + TRY_W'(1);
                        state_d = (tries_d == TRY_W'(MAX_TRIES)) ? ST_ALARM : ST_DENY;
                    end
                end else if (tmr_done) begin
                    state_d = ST_IDLE;
                    pulse_d = 1'b1;
                end
            end
            ST_DENY: begin
                if (tmr_done) begin
                    state_d  = ST_WAIT_PW;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(PW_TIMEOUT - 1);
                end
            end
            ST_ENTER: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                    if (!full) parked_d = parked_q + CNT_W'(1);
                end
            end
            ST_EXIT: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                    if (parked_q != '0) parked_d = parked_q - CNT_W'(1);
                end
            end
            ST_ALARM: begin
                if (alarm_clr_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            lane_q   <= LANE_ENTRY;
            tries_q  <= '0;
            parked_q <= '0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            tries_q  <= tries_d;
            parked_q <= parked_d;
            pulse_q  <= pulse_d;
        end
    end

    assign gate_open_o        = (state_q == ST_ENTER) || (state_q == ST_EXIT);
    assign green_led_o        = gate_open_o;
    assign red_led_o          = (state_q == ST_DENY) || (state_q == ST_ALARM) || pulse_q;
    assign gate_lane_o        = lane_q;
    assign parked_spaces_o    = parked_q;
    assign available_spaces_o = CNT_W'(CAPACITY) - parked_q;
    assign full_o             = full;
    assign busy_o             = (state_q != ST_IDLE);
    assign alarm_o            = (state_q == ST_ALARM);

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// tb/tb_parking_gate_scheduler.sv - directed bench with a session-level reference model
module tb_parking_gate_scheduler;

    localparam int CAP = 8;
    localparam int GC  = 4;
    localparam int PWT = 8;
    localparam int MT  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       entry_s = 1'b0, exit_s = 1'b0, pw_valid = 1'b0, alarm_clr = 1'b0;
    logic [1:0] pw1 = 2'b00, pw2 = 2'b00;
    logic       gate_open, gate_lane, green, red, full, busy, alarm;
    logic [3:0] parked, avail;

    int n_checks = 0;
    int n_fail   = 0;

    parking_gate_scheduler dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .entry_sensor_i     (entry_s),
        .exit_sensor_i      (exit_s),
        .pw_valid_i         (pw_valid),
        .password_1_i       (pw1),
        .password_2_i       (pw2),
        .alarm_clr_i        (alarm_clr),
        .gate_open_o        (gate_open),
        .gate_lane_o        (gate_lane),
        .green_led_o        (green),
        .red_led_o          (red),
        .parked_spaces_o    (parked),
        .available_spaces_o (avail),
        .full_o             (full),
        .busy_o             (busy),
        .alarm_o            (alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Session-level model: a phase plus the number of cycles it still has to run.
    typedef enum {M_IDLE, M_PW, M_DENY, M_GATE, M_ALARM} mph_t;
    mph_t m_ph     = M_IDLE;
    int   m_left   = 0;
    int   m_lane   = 0;
    int   m_tries  = 0;
    int   m_parked = 0;
    int   m_pulse  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = M_IDLE; m_left = 0; m_lane = 0; m_tries = 0; m_parked = 0; m_pulse = 0;
        end else begin
            m_pulse = 0;
            case (m_ph)
                M_IDLE: begin
                    bit want_in, want_out;
                    want_in  = entry_s && (m_parked < CAP);
                    want_out = exit_s && (m_parked > 0);
                    if (want_in || want_out) begin
                        if (want_in && want_out) m_lane = 1 - m_lane;
                        else m_lane = want_out ? 1 : 0;
                        if (m_lane == 0) begin
                            m_ph = M_PW; m_left = PWT; m_tries = 0;
                        end else begin
                            m_ph = M_GATE; m_left = GC;
                        end
                    end
                end
                M_PW: begin
                    if (pw_valid) begin
                        if (pw1 == 2'b01 && pw2 == 2'b10) begin
                            m_ph = M_GATE; m_left = GC;
                        end else begin
                            m_tries++;
                            if (m_tries == MT) m_ph = M_ALARM;
                            else begin m_ph = M_DENY; m_left = GC; end
                        end
                    end else begin
                        m_left--;
                        if (m_left == 0) begin m_ph = M_IDLE; m_pulse = 1; end
                    end
                end
                M_DENY: begin
                    m_left--;
                    if (m_left == 0) begin m_ph = M_PW; m_left = PWT; end
                end
                M_GATE: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_parked += (m_lane == 1) ? -1 : 1;
                        m_ph = M_IDLE;
                    end
                end
                M_ALARM: if (alarm_clr) m_ph = M_IDLE;
                default: m_ph = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("cmp gate_open", int'(gate_open), int'(m_ph == M_GATE));
        chk("cmp green_led", int'(green), int'(m_ph == M_GATE));
        chk("cmp red_led", int'(red), int'(m_ph == M_DENY || m_ph == M_ALARM || m_pulse == 1));
        chk("cmp busy", int'(busy), int'(m_ph != M_IDLE));
        chk("cmp alarm", int'(alarm), int'(m_ph == M_ALARM));
        chk("cmp gate_lane", int'(gate_lane), m_lane);
        chk("cmp parked", int'(parked), m_parked);
        chk("cmp available", int'(avail), CAP - m_parked);
        chk("cmp full", int'(full), int'(m_parked == CAP));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_pw(input logic [1:0] a, input logic [1:0] b);
        pw1 = a; pw2 = b; pw_valid = 1'b1;
        step();
        pw_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 60) begin step(); c++; end
        if (busy) chk("wait_idle timeout", 1, 0);
    endtask

    task automatic do_entry();
        entry_s = 1'b1; step(); entry_s = 1'b0;
        pulse_pw(2'b01, 2'b10);
        wait_idle();
    endtask

    task automatic do_exit();
        exit_s = 1'b1; step(); exit_s = 1'b0;
        wait_idle();
    endtask

    initial begin
        int g, ng, reds, red_at, prev_go;
        int lanes[4];

        repeat (3) step();
        rst_n = 1'b1;
        chk("reset gate_open", int'(gate_open), 0);
        chk("reset parked", int'(parked), 0);
        chk("reset available", int'(avail), 8);
        chk("reset busy", int'(busy), 0);
        chk("reset gate_lane", int'(gate_lane), 0);

        // Basic entry with correct password.
        entry_s = 1'b1; step(); entry_s = 1'b0;
        chk("entry grant busy", int'(busy), 1);
        chk("entry no gate before pw", int'(gate_open), 0);
        pulse_pw(2'b01, 2'b10);
        g = 0;
        for (int i = 0; i < 10; i++) begin g += int'(gate_open); step(); end
        chk("entry gate cycles", g, 4);
        chk("entry parked", int'(parked), 1);
        chk("entry gate_lane", int'(gate_lane), 0);

        // Reset in the middle of an ENTER session.
        entry_s = 1'b1; step(); entry_s = 1'b0;
        pulse_pw(2'b01, 2'b10);
        step();
        rst_n = 1'b0;
        #1;
        chk("midreset gate_open", int'(gate_open), 0);
        chk("midreset parked", int'(parked), 0);
        chk("midreset available", int'(avail), 8);
        chk("midreset busy", int'(busy), 0);
        step();
        rst_n = 1'b1;

        // Round-robin with both lanes held.
        do_entry();
        do_entry();
        chk("rr start parked", int'(parked), 2);
        entry_s = 1'b1; exit_s = 1'b1; ng = 0; prev_go = 0;
        for (int c = 0; c < 200 && ng < 4; c++) begin
            if (gate_open && prev_go == 0) begin lanes[ng] = int'(gate_lane); ng++; end
            prev_go = int'(gate_open);
            if (busy && !gate_open && !red) begin
                pw1 = 2'b01; pw2 = 2'b10; pw_valid = 1'b1;
            end else begin
                pw_valid = 1'b0;
            end
            step();
        end
        pw_valid = 1'b0; entry_s = 1'b0; exit_s = 1'b0;
        chk("rr grants", ng, 4);
        chk("rr lane0", lanes[0], 1);
        chk("rr lane1", lanes[1], 0);
        chk("rr lane2", lanes[2], 1);
        chk("rr lane3", lanes[3], 0);
        wait_idle();
        chk("rr end parked", int'(parked), 2);

        // Full car park: entry blocked, exit served, then the waiting entry.
        for (int k = 0; k < 6; k++) do_entry();
        chk("full flag", int'(full), 1);
        chk("full available", int'(avail), 0);
        entry_s = 1'b1;
        for (int k = 0; k < 3; k++) begin step(); chk("full no grant", int'(busy), 0); end
        exit_s = 1'b1; step(); exit_s = 1'b0;
        chk("exit latency gate_open", int'(gate_open), 1);
        chk("exit gate_lane", int'(gate_lane), 1);
        repeat (4) step();
        chk("exit parked", int'(parked), 7);
        chk("exit idle", int'(busy), 0);
        step();
        entry_s = 1'b0;
        chk("entry after exit busy", int'(busy), 1);
        chk("entry after exit lane", int'(gate_lane), 0);
        pulse_pw(2'b01, 2'b10);
        wait_idle();
        chk("refill parked", int'(parked), 8);
        do_exit();

        // Three wrong passwords lead to alarm.
        entry_s = 1'b1; step(); entry_s = 1'b0;
        pulse_pw(2'b00, 2'b00);
        chk("deny1 red", int'(red), 1);
        repeat (4) step();
        chk("deny1 back to wait red", int'(red), 0);
        pulse_pw(2'b01, 2'b01);
        chk("deny2 red", int'(red), 1);
        chk("deny2 alarm", int'(alarm), 0);
        repeat (4) step();
        pulse_pw(2'b10, 2'b10);
        chk("alarm set", int'(alarm), 1);
        chk("alarm red", int'(red), 1);
        entry_s = 1'b1;
        repeat (5) step();
        entry_s = 1'b0;
        chk("alarm held", int'(alarm), 1);
        alarm_clr = 1'b1; step(); alarm_clr = 1'b0;
        chk("alarm cleared", int'(alarm), 0);
        chk("alarm cleared idle", int'(busy), 0);
        chk("alarm parked", int'(parked), 7);

        // Password timeout.
        entry_s = 1'b1; step(); entry_s = 1'b0;
        reds = 0; red_at = -1; g = 0;
        for (int k = 0; k < 12; k++) begin
            if (red) begin reds++; red_at = k; end
            g += int'(gate_open);
            if (k == 9) chk("timeout idle", int'(busy), 0);
            step();
        end
        chk("timeout red pulses", reds, 1);
        chk("timeout red cycle", red_at, 8);
        chk("timeout gate never", g, 0);
        chk("timeout parked", int'(parked), 7);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
